// File: rtl/mem_port_arb.sv
// Memory-port arbiter: serialises NCH requesters onto one registered memory port with
// MEMRDY wait handshake, fixed-priority or round-robin grant, and an optional bus timeout.
module mem_port_arb #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ARB_RR  = 0,
   parameter int unsigned TMO_CYC = 64
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NCH-1:0]          req,
   input  logic [NCH-1:0]          we,
   input  logic [NCH*ADDR_W-1:0]   req_addr,
   input  logic [NCH*DATA_W-1:0]   req_wdata,
   output logic [NCH-1:0]          done,
   output logic [DATA_W-1:0]       rdata,
   output logic                    err,
   output logic                    err_sticky,
   output logic [$clog2(NCH)-1:0]  err_ch,
   output logic                    busy,
   output logic [ADDR_W-1:0]       addr,
   output logic [DATA_W-1:0]       memDat,
   output logic                    memWrite,
   input  logic [DATA_W-1:0]       MEMD,
   input  logic                    MEMRDY
);

   localparam int unsigned CH_W  = $clog2(NCH);
   localparam int unsigned CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, win;
   logic [CH_W:0]       idx;
   logic                found, tmo_hit;
   logic [ADDR_W-1:0]   sel_addr, addr_q, addr_d;
   logic [DATA_W-1:0]   sel_wdata, mem_dat_q, mem_dat_d, rdata_q, rdata_d;
   logic [NCH-1:0]      done_q, done_d;
   logic                err_q, err_d, err_sticky_q, err_sticky_d, busy_q, busy_d;
   logic                mem_write_q, mem_write_d;
   logic [CH_W-1:0]     err_ch_q, err_ch_d;

   // Search starts at the round-robin pointer, or at channel 0 in fixed-priority mode.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (ARB_RR != 0) begin
            idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NCH)) idx = idx - (CH_W+1)'(NCH);
         end else begin
            idx = (CH_W+1)'(i);
         end
         if (!found && req[idx[CH_W-1:0]]) begin
            found = 1'b1;
            win   = idx[CH_W-1:0];
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (win == CH_W'(i)) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   if (TMO_CYC > 0) begin : g_tmo
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            cnt_q <= '0;
         end else if (state_q != StWait) begin
            cnt_q <= '0;
         end else if (!MEMRDY && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign tmo_hit = (state_q == StWait) && !MEMRDY && (cnt_q == CNT_W'(TMO_CYC - 1));
   end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rr_ptr_d     = rr_ptr_q;
      addr_d       = addr_q;
      mem_dat_d    = mem_dat_q;
      mem_write_d  = mem_write_q;
      rdata_d      = rdata_q;
      done_d       = '0;
      err_d        = 1'b0;
      err_sticky_d = err_sticky_q;
      err_ch_d     = err_ch_q;
      busy_d       = busy_q;
      case (state_q)
         StIdle: begin
            if (|req) begin
               gnt_d       = win;
               rr_ptr_d    = (win == CH_W'(NCH - 1)) ? '0 : win + 1'b1;
               addr_d      = sel_addr;
               mem_dat_d   = sel_wdata;
               mem_write_d = we[win];
               busy_d      = 1'b1;
               state_d     = StWait;
            end else begin
               addr_d      = '0;
               mem_dat_d   = '0;
               mem_write_d = 1'b0;
            end
         end
         StWait: begin
            if (MEMRDY) begin
               rdata_d        = MEMD;
               done_d[gnt_q]  = 1'b1;
               mem_write_d    = 1'b0;
               state_d        = StDone;
            end else if (tmo_hit) begin
               rdata_d        = '0;
               done_d[gnt_q]  = 1'b1;
               err_d          = 1'b1;
               err_sticky_d   = 1'b1;
               err_ch_d       = gnt_q;
               mem_write_d    = 1'b0;
               state_d        = StDone;
            end
         end
         StDone: begin
            addr_d  = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= StIdle;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         addr_q       <= '0;
         mem_dat_q    <= '0;
         mem_write_q  <= 1'b0;
         rdata_q      <= '0;
         done_q       <= '0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         err_ch_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rr_ptr_q     <= rr_ptr_d;
         addr_q       <= addr_d;
         mem_dat_q    <= mem_dat_d;
         mem_write_q  <= mem_write_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
         err_ch_q     <= err_ch_d;
         busy_q       <= busy_d;
      end
   end

   assign done       = done_q;
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign err_sticky = err_sticky_q;
   assign err_ch     = err_ch_q;
   assign busy       = busy_q;
   assign addr       = addr_q;
   assign memDat     = mem_dat_q;
   assign memWrite   = mem_write_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a fixed-priority and a round-robin instance (both TMO_CYC=8)
// share the memory-side inputs; completions are checked against a scoreboard queue.
module tb_mem_port_arb;

   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int DW  = 16;

   logic                CLK = 1'b0;
   logic                RST_N = 1'b0;
   logic [NCH-1:0]      req_f, req_r, we;
   logic [NCH*AW-1:0]   req_addr;
   logic [NCH*DW-1:0]   req_wdata;
   logic [DW-1:0]       MEMD;
   logic                MEMRDY;

   logic [NCH-1:0] done_f, done_r;
   logic [DW-1:0]  rdata_f, rdata_r, mem_dat_f, mem_dat_r;
   logic           err_f, err_r, err_sticky_f, err_sticky_r, busy_f, busy_r;
   logic           mem_write_f, mem_write_r;
   logic [1:0]     err_ch_f, err_ch_r;
   logic [AW-1:0]  addr_f, addr_r;

   mem_port_arb #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(0), .TMO_CYC(8)) dut_f (
      .CLK(CLK), .RST_N(RST_N), .req(req_f), .we(we), .req_addr(req_addr),
      .req_wdata(req_wdata), .done(done_f), .rdata(rdata_f), .err(err_f),
      .err_sticky(err_sticky_f), .err_ch(err_ch_f), .busy(busy_f), .addr(addr_f),
      .memDat(mem_dat_f), .memWrite(mem_write_f), .MEMD(MEMD), .MEMRDY(MEMRDY)
   );

   mem_port_arb #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(1), .TMO_CYC(8)) dut_r (
      .CLK(CLK), .RST_N(RST_N), .req(req_r), .we(we), .req_addr(req_addr),
      .req_wdata(req_wdata), .done(done_r), .rdata(rdata_r), .err(err_r),
      .err_sticky(err_sticky_r), .err_ch(err_ch_r), .busy(busy_r), .addr(addr_r),
      .memDat(mem_dat_r), .memWrite(mem_write_r), .MEMD(MEMD), .MEMRDY(MEMRDY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int            ch;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Returns the first non-zero done vector seen at a falling edge, or 0 when the budget expires.
   task automatic wait_done(input bit use_rr, input int budget, output logic [3:0] d,
                            output int cycles);
      d = '0;
      cycles = 0;
      while (cycles < budget) begin
         @(negedge CLK);
         cycles++;
         d = use_rr ? done_r : done_f;
         if (d != 4'b0000) break;
      end
   endtask

   task automatic push_exp(input int ch, input logic [DW-1:0] rd, input logic e_err);
      exp_t e;
      e.ch = ch;
      e.rdata = rd;
      e.err = e_err;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      checks++;
      if ({done_f, err_f, err_sticky_f, busy_f, mem_write_f} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl_f got %b want 0", {done_f, err_f, err_sticky_f, busy_f,
                  mem_write_f});
      end
      checks++;
      if ({addr_f, mem_dat_f, rdata_f, err_ch_f} !== 66'h0) begin
         errors++;
         $display("FAIL reset_data_f got addr %h dat %h rdata %h ch %0d want 0", addr_f,
                  mem_dat_f, rdata_f, err_ch_f);
      end
      checks++;
      if ({done_r, err_r, err_sticky_r, busy_r, mem_write_r, addr_r} !== 40'h0) begin
         errors++;
         $display("FAIL reset_r got done %b busy %b addr %h want 0", done_r, busy_r, addr_r);
      end
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if (busy_f !== 1'b0 || done_f !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_reset got busy %b done %b want 0", busy_f, done_f);
      end
   endtask

   task automatic test_single_load();
      logic [3:0] d;
      int cyc;
      exp_t e;
      @(negedge CLK);
      req_addr[1*AW +: AW] = 32'h0000_1234;
      we = '0;
      MEMD = 16'hBEEF;
      MEMRDY = 1'b0;
      req_f = 4'b0010;
      push_exp(1, 16'hBEEF, 1'b0);
      @(negedge CLK);
      checks++;
      if (addr_f !== 32'h0000_1234) begin
         errors++;
         $display("FAIL load_addr got %h want 00001234", addr_f);
      end
      checks++;
      if (busy_f !== 1'b1 || mem_write_f !== 1'b0 || done_f !== 4'b0000) begin
         errors++;
         $display("FAIL load_wait got busy %b we %b done %b want 1 0 0000", busy_f,
                  mem_write_f, done_f);
      end
      MEMRDY = 1'b1;
      wait_done(1'b0, 4, d, cyc);
      e = sb_q.pop_front();
      checks++;
      if (cyc !== 1) begin
         errors++;
         $display("FAIL load_latency got %0d want 1", cyc);
      end
      checks++;
      if (d !== 4'(1 << e.ch) || rdata_f !== e.rdata || err_f !== e.err) begin
         errors++;
         $display("FAIL load_done got done %b rdata %h err %b want %b %h %b", d, rdata_f,
                  err_f, 4'(1 << e.ch), e.rdata, e.err);
      end
      checks++;
      if (mem_write_f !== 1'b0) begin
         errors++;
         $display("FAIL load_memwrite got %b want 0", mem_write_f);
      end
      req_f = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
      checks++;
      if (done_f !== 4'b0000 || busy_f !== 1'b0 || addr_f !== 32'h0) begin
         errors++;
         $display("FAIL load_after got done %b busy %b addr %h want 0 0 0", done_f, busy_f,
                  addr_f);
      end
   endtask

   task automatic test_write_wait();
      logic [3:0] d;
      int cyc;
      int wr_cnt;
      exp_t e;
      @(negedge CLK);
      req_addr[2*AW +: AW] = 32'h0000_2000;
      req_wdata[2*DW +: DW] = 16'h5A5A;
      we = 4'b0100;
      MEMRDY = 1'b0;
      MEMD = 16'h1111;
      req_f = 4'b0100;
      push_exp(2, 16'h1111, 1'b0);
      wr_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (mem_write_f === 1'b1) wr_cnt++;
         checks++;
         if (mem_dat_f !== 16'h5A5A || done_f !== 4'b0000) begin
            errors++;
            $display("FAIL write_hold[%0d] got dat %h done %b want 5a5a 0000", i, mem_dat_f,
                     done_f);
         end
      end
      MEMRDY = 1'b1;
      wait_done(1'b0, 4, d, cyc);
      e = sb_q.pop_front();
      checks++;
      if (d !== 4'(1 << e.ch) || rdata_f !== e.rdata || cyc !== 1) begin
         errors++;
         $display("FAIL write_done got done %b rdata %h cyc %0d want %b %h 1", d, rdata_f, cyc,
                  4'(1 << e.ch), e.rdata);
      end
      checks++;
      if (wr_cnt !== 6 || mem_write_f !== 1'b0) begin
         errors++;
         $display("FAIL write_strobe got %0d cycles, end %b want 6 cycles, end 0", wr_cnt,
                  mem_write_f);
      end
      req_f = '0;
      we = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_fixed_priority();
      logic [3:0] d;
      int cyc;
      exp_t e;
      @(negedge CLK);
      MEMRDY = 1'b1;
      MEMD = 16'h0C00;
      req_f = 4'hF;
      for (int n = 0; n < 4; n++) push_exp(n, 16'h0C00, 1'b0);
      for (int n = 0; n < 4; n++) begin
         wait_done(1'b0, 8, d, cyc);
         e = sb_q.pop_front();
         checks++;
         if (d !== 4'(1 << e.ch) || rdata_f !== e.rdata) begin
            errors++;
            $display("FAIL fixed_order[%0d] got done %b rdata %h want %b %h", n, d, rdata_f,
                     4'(1 << e.ch), e.rdata);
         end
         req_f = req_f & ~d;
      end
      req_f = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_round_robin();
      logic [3:0] d;
      int cyc;
      exp_t e;
      @(negedge CLK);
      MEMRDY = 1'b1;
      MEMD = 16'h0D00;
      req_r = 4'hF;
      for (int n = 0; n < 5; n++) push_exp(n % 4, 16'h0D00, 1'b0);
      for (int n = 0; n < 5; n++) begin
         wait_done(1'b1, 8, d, cyc);
         e = sb_q.pop_front();
         checks++;
         if (d !== 4'(1 << e.ch)) begin
            errors++;
            $display("FAIL rr_order[%0d] got done %b want %b", n, d, 4'(1 << e.ch));
         end
         req_r = req_r & ~(d & 4'b1110);
      end
      req_r = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_timeout();
      logic [3:0] d;
      int cyc;
      exp_t e;
      @(negedge CLK);
      req_addr[3*AW +: AW] = 32'h0000_3000;
      we = '0;
      MEMRDY = 1'b0;
      MEMD = 16'hFFFF;
      req_f = 4'b1000;
      push_exp(3, 16'h0000, 1'b1);
      @(negedge CLK);
      wait_done(1'b0, 20, d, cyc);
      e = sb_q.pop_front();
      checks++;
      if (cyc !== 8) begin
         errors++;
         $display("FAIL tmo_latency got %0d want 8", cyc);
      end
      checks++;
      if (d !== 4'(1 << e.ch) || rdata_f !== e.rdata || err_f !== e.err) begin
         errors++;
         $display("FAIL tmo_done got done %b rdata %h err %b want %b %h %b", d, rdata_f, err_f,
                  4'(1 << e.ch), e.rdata, e.err);
      end
      checks++;
      if (err_sticky_f !== 1'b1 || err_ch_f !== 2'd3) begin
         errors++;
         $display("FAIL tmo_status got sticky %b ch %0d want 1 3", err_sticky_f, err_ch_f);
      end
      req_f = '0;
      @(negedge CLK);
      checks++;
      if (err_f !== 1'b0 || err_sticky_f !== 1'b1) begin
         errors++;
         $display("FAIL tmo_pulse got err %b sticky %b want 0 1", err_f, err_sticky_f);
      end
      req_f = 4'b0001;
      MEMD = 16'h0042;
      MEMRDY = 1'b1;
      push_exp(0, 16'h0042, 1'b0);
      wait_done(1'b0, 6, d, cyc);
      e = sb_q.pop_front();
      checks++;
      if (d !== 4'(1 << e.ch) || rdata_f !== e.rdata || err_f !== e.err ||
          err_sticky_f !== 1'b1) begin
         errors++;
         $display("FAIL tmo_next got done %b rdata %h err %b sticky %b want %b %h %b 1", d,
                  rdata_f, err_f, err_sticky_f, 4'(1 << e.ch), e.rdata, e.err);
      end
      req_f = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_input_stability();
      logic [3:0] d;
      int cyc;
      exp_t e;
      @(negedge CLK);
      req_addr[0 +: AW] = 32'hAAAA_0000;
      req_wdata[0 +: DW] = 16'h1234;
      we = '0;
      MEMRDY = 1'b0;
      MEMD = 16'h7777;
      req_f = 4'b0001;
      push_exp(0, 16'h7777, 1'b0);
      @(negedge CLK);
      req_addr[0 +: AW] = 32'h5555_0000;
      req_wdata[0 +: DW] = 16'h9999;
      we = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if (addr_f !== 32'hAAAA_0000 || mem_dat_f !== 16'h1234 || mem_write_f !== 1'b0) begin
            errors++;
            $display("FAIL stable[%0d] got addr %h dat %h we %b want aaaa0000 1234 0", i,
                     addr_f, mem_dat_f, mem_write_f);
         end
      end
      MEMRDY = 1'b1;
      wait_done(1'b0, 4, d, cyc);
      e = sb_q.pop_front();
      checks++;
      if (d !== 4'(1 << e.ch) || rdata_f !== e.rdata) begin
         errors++;
         $display("FAIL stable_done got done %b rdata %h want %b %h", d, rdata_f,
                  4'(1 << e.ch), e.rdata);
      end
      req_f = '0;
      we = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
      checks++;
      if (addr_f !== 32'h0) begin
         errors++;
         $display("FAIL stable_release got addr %h want 0", addr_f);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [3:0] d;
      int cyc;
      bit saw_done;
      exp_t e;
      @(negedge CLK);
      req_addr[2*AW +: AW] = 32'h0000_2200;
      req_wdata[2*DW +: DW] = 16'hC3C3;
      we = 4'b0100;
      MEMRDY = 1'b0;
      req_r = 4'b0100;
      @(negedge CLK);
      checks++;
      if (mem_write_r !== 1'b1 || busy_r !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre got we %b busy %b want 1 1", mem_write_r, busy_r);
      end
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if (mem_write_r !== 1'b0 || addr_r !== 32'h0 || busy_r !== 1'b0 ||
          mem_dat_r !== 16'h0) begin
         errors++;
         $display("FAIL rst_async got we %b addr %h busy %b dat %h want 0", mem_write_r,
                  addr_r, busy_r, mem_dat_r);
      end
      checks++;
      if (err_sticky_f !== 1'b0 || err_ch_f !== 2'd0) begin
         errors++;
         $display("FAIL rst_sticky got sticky %b ch %0d want 0 0", err_sticky_f, err_ch_f);
      end
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         if (done_r !== 4'b0000) saw_done = 1'b1;
      end
      req_r = '0;
      we = '0;
      RST_N = 1'b1;
      @(negedge CLK);
      if (done_r !== 4'b0000) saw_done = 1'b1;
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_done got a done pulse want none");
      end
      req_r = 4'b0011;
      MEMD = 16'h0BAD;
      MEMRDY = 1'b1;
      push_exp(0, 16'h0BAD, 1'b0);
      wait_done(1'b1, 6, d, cyc);
      e = sb_q.pop_front();
      checks++;
      if (d !== 4'(1 << e.ch) || rdata_r !== e.rdata) begin
         errors++;
         $display("FAIL rst_after got done %b rdata %h want %b %h", d, rdata_r,
                  4'(1 << e.ch), e.rdata);
      end
      req_r = '0;
      MEMRDY = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      req_f = '0;
      req_r = '0;
      we = '0;
      req_addr = '0;
      req_wdata = '0;
      MEMD = '0;
      MEMRDY = 1'b0;
      test_reset();
      test_single_load();
      test_write_wait();
      test_fixed_priority();
      test_round_robin();
      test_timeout();
      test_input_stability();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish by 200000");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Parametrised memory-port arbiter for the CPU core family. It serialises NCH independent requesters onto the single memory port (addr / memDat / memWrite / MEMD / MEMRDY), for example instruction fetch, load/store and stack push/pop. It honours the MEMRDY wait handshake and adds a bus timeout with error reporting. It sits between the pipeline stages and external RAM and replaces per-stage address muxing with one registered, stall-aware port.

## Interface
Parameters:
- NCH, 4: number of requesting channels (≥2); channel 0 is the highest fixed priority.
- ADDR_W, 32: address width.
- DATA_W, 16: data width.
- ARB_RR, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TMO_CYC, 64: WAIT cycles without MEMRDY before a timeout abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req  in  NCH  per-channel request level; held until that channel's done.
- we  in  NCH  per-channel write enable (1 = store, 0 = load).
- req_addr  in  NCH*ADDR_W  channel i address at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NCH*DATA_W  channel i write data, packed the same way.
- done  out  NCH  one-cycle completion pulse for the granted channel.
- rdata  out  DATA_W  captured MEMD; valid while any done bit is high.
- err  out  1  one-cycle pulse, coincident with done, when an access timed out.
- err_sticky  out  1  set on any timeout; cleared only by reset.
- err_ch  out  $clog2(NCH)  channel index of the most recent timeout.
- busy  out  1  high in WAIT and DONE.
- addr  out  ADDR_W  memory address.
- memDat  out  DATA_W  memory write data.
- memWrite  out  1  memory write strobe.
- MEMD  in  DATA_W  memory read data.
- MEMRDY  in  1  memory ready; completes the current access.

## Operation
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE, when req≠0:
  - Select the winner g.
  - Latch g, addr←req_addr[g], memDat←req_wdata[g], memWrite←we[g].
  - Clear the timeout counter and go to WAIT.
- IDLE, when req=0: addr, memDat and memWrite hold 0.
- WAIT, when MEMRDY=1:
  - rdata←MEMD. This is captured for writes too and is don't-care to the requester.
  - done[g]←1, memWrite←0, go to DONE.
- WAIT, when MEMRDY=0:
  - The counter increments.
  - If TMO_CYC≠0 and the counter has reached TMO_CYC−1 (TMO_CYC consecutive low cycles), take the abort path: done[g]←1, err←1, err_sticky←1, err_ch←g, memWrite←0, rdata←0, go to DONE.
- DONE:
  - done and err drop to 0 and addr returns to 0. Always go to IDLE; there is no arbitration in this state.
  - The requester must deassert req during the done cycle, otherwise it is re-arbitrated in IDLE.
- Fixed priority: g = lowest index with req set.
- Round-robin:
  - The pointer p (reset 0) marks the highest-priority channel.
  - The search order is p, p+1, …, NCH−1, 0, …, p−1.
  - On each grant, p←(g+1) mod NCH, wrapping at NCH−1→0.
  - A timed-out access advances p like a normal grant.
- req, we, req_addr and req_wdata are sampled only in IDLE. Changes during WAIT are ignored.
- The timeout counter is $clog2(TMO_CYC+1) bits wide and saturates. It is not instantiated when TMO_CYC=0.
- Reset (RST_N low, asynchronous, including mid-access):
  - State←IDLE, p←0, counter←0.
  - done, err, err_sticky, err_ch, busy, addr, memDat, memWrite and rdata all go to 0 immediately.
  - An interrupted access produces no done.

## Timing
- The request is seen at edge E0 (IDLE). addr, memDat and memWrite are valid after E0 and stay stable through WAIT.
- MEMRDY is sampled at each WAIT edge. When MEMRDY is high before E1, done is high from E1 to E2.
- Minimum latency is req sampled → done asserted in 1 edge, with done visible during the cycle after E1.
- Minimum occupancy is 3 cycles per access (IDLE, WAIT, DONE); peak throughput is 1 access per 3 cycles.
- memWrite is high for exactly the WAIT cycles of a write and deasserts at the edge where done rises.
- Timeout: with MEMRDY held low, done and err rise TMO_CYC edges after entry to WAIT.
- busy is high from E0+ until the edge leaving DONE.

## Test plan
- Single load: ch1 requests addr 0x0000_1234 with we=0; MEMRDY is high one cycle later with MEMD=0xBEEF → addr=0x1234 during WAIT, done=4'b0010 for exactly 1 cycle, rdata=0xBEEF, memWrite stays 0.
- Write with waits: ch2 has we=1, data 0x5A5A, MEMRDY delayed 5 cycles → memWrite high for exactly 6 WAIT cycles, memDat=0x5A5A throughout, then done[2] pulses.
- Fixed priority vs round-robin: all four channels request continuously and drop req on done, MEMRDY is always 1:
  - ARB_RR=0 → grant order 0,1,2,3.
  - ARB_RR=1 with ch0 re-asserting immediately → order 0,1,2,3,0 (ch0 cannot starve ch1–3).
- Timeout: TMO_CYC=8, ch3 requests and MEMRDY stays 0 → done[3] and err pulse 8 edges after entering WAIT, rdata=0, err_sticky=1, err_ch=3. A following normal access completes with err=0 and err_sticky still 1.
- Reset mid-access: drop RST_N during WAIT of a write → memWrite, addr and busy go to 0 asynchronously, no done pulse; after release, a ch0 request completes normally with round-robin pointer p=0.
- Input stability: change req_addr of the granted channel during WAIT → addr is unchanged until DONE.
